instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Registered, parametrised RV32I decode stage between fetch and execute.
//  Splits each instruction into opcode, funct3, funct7, rs1, rs2 and rd, and builds the
//  sign-extended immediate plus a format code. PC travels alongside the instruction.
//  Valid/ready on both sides; a 2-entry skid buffer absorbs back-pressure; flush squashes in-flight work.
// PARAMETERS
//  XLEN  32  immediate/datapath width (32 or 64); imm sign-extended to XLEN
//  PC_W  32  width of the PC carried with each instruction
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     squash all held entries (branch redirect)
//  in_valid   in   1     upstream holds a valid instruction
//  in_ready   out  1     stage accepts an instruction this cycle
//  in_instr   in   32    raw instruction word
//  in_pc      in   PC_W  PC of in_instr
//  out_valid  out  1     decoded entry at head is valid
//  out_ready  in   1     downstream consumes head this cycle
//  out_pc     out  PC_W  PC of head entry
//  opcode     out  7     instr[6:0]
//  funct3     out  3     instr[14:12]
//  funct7     out  7     instr[31:25]
//  rs1        out  5     instr[19:15]
//  rs2        out  5     instr[24:20]
//  rd         out  5     instr[11:7]
//  imm        out  XLEN  sign-extended immediate
//  fmt        out  3     0=R 1=I 2=S 3=B 4=U 5=J 7=unknown
//  illegal    out  1     opcode not in RV32I base set (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: both entries empty; out_valid=0, in_ready=1; all data outputs 0 (fmt=0, illegal=0).
//  - Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready.
//  - Latency: accepted instr appears on outputs next cycle (1 cycle); decode happens before storage.
//  - Storage: 2-entry FIFO (head/skid). in_ready = (count<2), registered, no comb path from out_ready.
//    Simultaneous push+pop at count=1: count stays 1, new entry becomes head next cycle.
//    Simultaneous push+pop at count=2: not possible, because in_ready=0.
//  - Order strictly preserved; head outputs stable while out_valid & !out_ready.
//  - Imm by opcode: I (0010011,0000011,1100111,1110011): sext(i[31:20]).
//    S (0100011): sext({i[31:25],i[11:7]}).
//    B (1100011): sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
//    U (0110111,0010111): sext({i[31:12],12'b0}).
//    J (1101111): sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
//    R (0110011): imm=0. Fence 0001111 is I format.
//    Unknown opcode: fmt=7, imm=0.
//  - Sign extension is from the top immediate bit to XLEN; for U with XLEN=64, bits 63:32 copy i[31].
//  - Flush: next edge count=0, out_valid=0, in_ready=1. An in_valid in the same cycle as flush is dropped.
//    Flush has priority over push and pop.
//  - Reset mid-operation: state clears immediately (async); no output pulse after release.
// CONFIGURATION
//  DECODE_ILLEGAL_CHK_EN defined: illegal=1 when fmt=7, or i[1:0]!=2'b11,
//    or (R-type and funct7 not in {0000000,0100000}). The entry still flows with its fields.
//  Undefined: illegal tied to 0; no check logic synthesised; fmt/imm unchanged.
// TESTING
//  1. Push 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle opcode=0x13 rd=1 rs1=0 imm=5 fmt=1.
//  2. Push 0xFE000EE3 (beq x0,x0,-4) -> fmt=3 imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC).
//  3. Push 0x123452B7 (lui x5,0x12345) -> fmt=4 rd=5 imm=0x12345000.
//  4. out_ready=0, push 3 instrs back-to-back -> in_ready=0 after 2 accepted; 3rd held upstream;
//     then raise out_ready -> all 3 emerge in order, one per cycle.
//  5. 2 entries held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed instr lost.
//  6. Push 0xFFFFFFFF -> fmt=7 imm=0; illegal=1 with DECODE_ILLEGAL_CHK_EN, 0 without.
//     Deassert rst_n mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32I decode with 2-entry skid FIFO and flush.
// Optional illegal-instruction checking is enabled by defining DECODE_ILLEGAL_CHK_EN.
module instr_decode_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            ill;
   } ent_t;

   ent_t               head, skid, d;
   logic [1:0]         cnt;
   logic               push, pop, dill;
   logic [2:0]         dfmt;
   logic signed [31:0] imm32;
   logic [31:0]        i;

   assign i = in_instr;

   always_comb begin
      dfmt  = 3'd7;
      imm32 = '0;
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
            dfmt  = 3'd1;
            imm32 = {{20{i[31]}}, i[31:20]};
         end
         7'b0100011: begin
            dfmt  = 3'd2;
            imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
         end
         7'b1100011: begin
            dfmt  = 3'd3;
            imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dfmt  = 3'd4;
            imm32 = {i[31:12], 12'b0};
         end
         7'b1101111: begin
            dfmt  = 3'd5;
            imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         end
         7'b0110011: dfmt = 3'd0;
         default: ;
      endcase
   end

`ifdef DECODE_ILLEGAL_CHK_EN
   assign dill = (dfmt == 3'd7) || (i[1:0] != 2'b11) ||
                 (dfmt == 3'd0 && i[31:25] != 7'b0000000 && i[31:25] != 7'b0100000);
`else
   assign dill = 1'b0;
`endif

   // signed source makes the size cast sign-extend for XLEN=64
   assign d = '{pc: in_pc, instr: in_instr, imm: XLEN'(imm32), fmt: dfmt, ill: dill};

   assign in_ready  = (cnt != 2'd2);
   assign out_valid = (cnt != 2'd0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         head <= '0;
         skid <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            if (cnt == 2'd2) head <= skid;
            else if (push) head <= d;
         end else if (push) begin
            if (cnt == 2'd0) head <= d;
            else skid <= d;
         end
      end
   end

   assign out_pc  = head.pc;
   assign opcode  = head.instr[6:0];
   assign rd      = head.instr[11:7];
   assign funct3  = head.instr[14:12];
   assign rs1     = head.instr[19:15];
   assign rs2     = head.instr[24:20];
   assign funct7  = head.instr[31:25];
   assign imm     = head.imm;
   assign fmt     = head.fmt;
   assign illegal = head.ill;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: table-driven decode checks plus back-pressure, flush and reset sequences.
module tb_instr_decode_stage;
   logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_instr = 0, in_pc = 0;
   logic        in_ready, out_valid, illegal;
   logic [31:0] out_pc, imm;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3, fmt;
   logic [4:0]  rs1, rs2, rd;
   int          errors = 0, checks = 0;

`ifdef DECODE_ILLEGAL_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   instr_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1),
      .rs2(rs2), .rd(rd), .imm(imm), .fmt(fmt), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } vec_t;

   vec_t v[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1;
      in_instr = ins;
      in_pc    = pc;
   endtask

   initial begin
      v[0]  = '{32'h00500093, 7'h13, 5'd1,  32'h00000005, 3'd1, 1'b0};
      v[1]  = '{32'hFE000EE3, 7'h63, 5'h1D, 32'hFFFFFFFC, 3'd3, 1'b0};
      v[2]  = '{32'h123452B7, 7'h37, 5'd5,  32'h12345000, 3'd4, 1'b0};
      v[3]  = '{32'h0020A423, 7'h23, 5'd8,  32'h00000008, 3'd2, 1'b0};
      v[4]  = '{32'hFE20AE23, 7'h23, 5'h1C, 32'hFFFFFFFC, 3'd2, 1'b0};
      v[5]  = '{32'h008000EF, 7'h6F, 5'd1,  32'h00000008, 3'd5, 1'b0};
      v[6]  = '{32'hFFDFF0EF, 7'h6F, 5'd1,  32'hFFFFFFFC, 3'd5, 1'b0};
      v[7]  = '{32'h002081B3, 7'h33, 5'd3,  32'h00000000, 3'd0, 1'b0};
      v[8]  = '{32'h022081B3, 7'h33, 5'd3,  32'h00000000, 3'd0, 1'b1};
      v[9]  = '{32'hFFF12283, 7'h03, 5'd5,  32'hFFFFFFFF, 3'd1, 1'b0};
      v[10] = '{32'h80000397, 7'h17, 5'd7,  32'h80000000, 3'd4, 1'b0};
      v[11] = '{32'h0FF0000F, 7'h0F, 5'd0,  32'h000000FF, 3'd1, 1'b0};
      v[12] = '{32'hFFFFFFFF, 7'h7F, 5'h1F, 32'h00000000, 3'd7, 1'b1};
      v[13] = '{32'h00000010, 7'h10, 5'd0,  32'h00000000, 3'd7, 1'b1};

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_data", {opcode, imm, fmt, illegal, out_pc}, 0);
      #3 rst_n = 1;
      tick();

      out_ready = 1;
      foreach (v[k]) begin
         drive(v[k].instr, 32'h1000 + 32'(k) * 4);
         tick();
         in_valid = 0;
         chk($sformatf("v%0d_valid", k), out_valid, 1);
         chk($sformatf("v%0d_opcode", k), opcode, v[k].op);
         chk($sformatf("v%0d_rd", k), rd, v[k].rd);
         chk($sformatf("v%0d_imm", k), imm, v[k].imm);
         chk($sformatf("v%0d_fmt", k), fmt, v[k].fmt);
         chk($sformatf("v%0d_illegal", k), illegal, v[k].ill & CHK);
         chk($sformatf("v%0d_pc", k), out_pc, 32'h1000 + 32'(k) * 4);
         if (k == 2) chk("lui_fields", {funct3, rs1, rs2, funct7}, {3'd5, 5'd8, 5'd3, 7'd9});
         tick();
         chk($sformatf("v%0d_drained", k), out_valid, 0);
      end

      // back-pressure: two accepted, third held, then drained in order
      out_ready = 0;
      drive(32'h00100093, 32'h2000);
      tick();
      chk("bp_ready_after1", in_ready, 1);
      drive(32'h00200093, 32'h2004);
      tick();
      chk("bp_ready_after2", in_ready, 0);
      drive(32'h00300093, 32'h2008);
      tick();
      chk("bp_still_full", in_ready, 0);
      chk("bp_head_stable", {out_pc, imm}, {32'h2000, 32'd1});
      out_ready = 1;
      tick();
      chk("bp_second", {out_valid, out_pc, imm}, {1'b1, 32'h2004, 32'd2});
      chk("bp_ready_reopen", in_ready, 1);
      tick();
      in_valid = 0;
      chk("bp_third", {out_valid, out_pc, imm}, {1'b1, 32'h2008, 32'd3});
      tick();
      chk("bp_empty", out_valid, 0);

      // flush with two held entries and a concurrent push
      out_ready = 0;
      drive(32'h00100093, 32'h3000);
      tick();
      drive(32'h00200093, 32'h3004);
      tick();
      drive(32'h00300093, 32'h3008);
      flush = 1;
      tick();
      flush = 0;
      in_valid = 0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      tick();
      chk("flush_push_lost", out_valid, 0);

      // asynchronous reset mid-stream
      drive(32'h00500093, 32'h4000);
      tick();
      in_valid = 0;
      chk("pre_rst_valid", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_ready", in_ready, 1);
      #4 rst_n = 1;
      tick();
      tick();
      chk("post_rst_quiet", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
